// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the 7-segment display blocks.
// Segments are active-high with bit0 = a .. bit6 = g.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of a ripple up/down counter; carry_out doubles as borrow.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  input  logic       dir,
  input  logic       carry_in,
  output logic [3:0] value,
  output logic       carry_out
);

  logic stepping;

  assign stepping  = step && carry_in;
  assign carry_out = stepping && (dir ? (value == BCD_MAX) : (value == 4'd0));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= 4'd0;
    end else if (stepping) begin
      if (dir) value <= (value == BCD_MAX) ? 4'd0 : value + 4'd1;
      else     value <= (value == 4'd0) ? BCD_MAX : value - 4'd1;
    end
  end

endmodule

// File: rtl/seg7.sv
// BCD to 7-segment decoder (combinational); non-decimal codes go blank.
module seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segments
);

  always_comb begin
    // NOTE: the default arm assigns the output on every path, so no latch is inferred.
    case (bcd)
      4'd0:    segments = SEG_0;
      4'd1:    segments = SEG_1;
      4'd2:    segments = SEG_2;
      4'd3:    segments = SEG_3;
      4'd4:    segments = SEG_4;
      4'd5:    segments = SEG_5;
      4'd6:    segments = SEG_6;
      4'd7:    segments = SEG_7;
      4'd8:    segments = SEG_8;
      4'd9:    segments = SEG_9;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_mux_counter.sv
// N-digit prescaled BCD up/down counter, time-multiplexed onto one 7-segment bus.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit0 always shown).
module seg7_mux_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int SCAN_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clear,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  tick,
  output logic                  wrap
);

  localparam int PRE_W  = $clog2(PRESCALE);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]  presc;
  logic              step;
  bcd_t              digit [NUM_DIGITS];
  logic [NUM_DIGITS:0] carry;
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  scan_idx;
  bcd_t              sel_digit;
  logic              sel_blank;
  logic [6:0]        dec_seg;
  logic [6:0]        seg_next;

  // clear outranks the terminal cycle, so a coincident clear suppresses the step.
  assign step = en && !clear && (presc == PRE_LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset || clear) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
    end
  end

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .step      (step),
      .dir       (dir),
      .carry_in  (carry[i]),
      .value     (digit[i]),
      .carry_out (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= step;
      wrap <= carry[NUM_DIGITS];
    end
  end

  // The scan free-runs independently of en and clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;

  always_comb begin
    logic seen;
    // NOTE: blocking assignments here build a top-down "non-zero seen" chain within one evaluation.
    seen  = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (digit[i] != 4'd0) seen = 1'b1;
      blank[i] = !seen;
    end
  end
`endif

  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        sel_digit = digit[i];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        sel_blank = blank[i];
`endif
      end
    end
  end

  seg7 u_seg7 (
    .bcd      (sel_digit),
    .segments (dec_seg)
  );

  assign seg_next = sel_blank ? SEG_BLANK : dec_seg;

  // Enable and segments are registered together from the same index, keeping them aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      segments <= '0;
      digit_en <= '0;
    end else begin
      segments <= seg_next;
      digit_en <= NUM_DIGITS'(1) << scan_idx;
    end
  end

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Scoreboard bench for seg7_mux_counter (NUM_DIGITS=4, PRESCALE=4, SCAN_DIV=2).
module tb_seg7_mux_counter;

  localparam int ND = 4;
  localparam int PS = 4;
  localparam int SD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          dir = 1'b1;
  logic          clear = 1'b0;
  logic [6:0]    segments;
  logic [ND-1:0] digit_en;
  logic          tick;
  logic          wrap;

  seg7_mux_counter #(
    .NUM_DIGITS (ND),
    .PRESCALE   (PS),
    .SCAN_DIV   (SD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .clear    (clear),
    .segments (segments),
    .digit_en (digit_en),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic wrap;
  } tick_exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  tick_exp_t   tick_q[$];
  int          disp_q[$];
  int          model_cnt = 0;
  int          model_p = 0;
  logic [6:0]  shadow [ND];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int cnt, input int i);
    int pow;
    pow = 1;
    for (int k = 0; k < i; k++) pow = pow * 10;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (i > 0 && cnt < pow) return 7'h00;
`endif
    return seg_of((cnt / pow) % 10);
  endfunction

  // Predict every tick of an en=1 window starting at the current negedge.
  task automatic plan_en(input int cycles);
    logic w;
    for (int t = 1; t <= cycles; t++) begin
      if (model_p == PS - 1) begin
        model_p = 0;
        w = 1'b0;
        if (dir) begin
          if (model_cnt == 9999) begin model_cnt = 0; w = 1'b1; end
          else model_cnt++;
        end else begin
          if (model_cnt == 0) begin model_cnt = 9999; w = 1'b1; end
          else model_cnt--;
        end
        tick_q.push_back('{cyc: cyc + t, wrap: w});
      end else begin
        model_p++;
      end
    end
  endtask

  task automatic run_en(input int cycles);
    plan_en(cycles);
    en = 1'b1;
    repeat (cycles) @(negedge clk);
    en = 1'b0;
  endtask

  task automatic check_display();
    disp_q.push_back(model_cnt);
    for (int k = 0; k < 40 && disp_q.size() != 0; k++) @(negedge clk);
    check("display_pending", disp_q.size(), 0);
  endtask

  // Tick/wrap monitor.
  always @(negedge clk) begin
    if (tick) begin
      if (tick_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick at cycle %0d: got tick=1 required tick=0", cyc);
      end else begin
        tick_exp_t e;
        e = tick_q.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_wrap", wrap, e.wrap);
      end
    end
    if (wrap) check("wrap_with_tick", tick, 1);
  end

  // Display monitor: collects one full scan and compares every digit.
  initial begin
    forever begin
      @(negedge clk);
      if (disp_q.size() != 0) begin
        for (int i = 0; i < ND; i++) shadow[i] = 'x;
        repeat (2) @(negedge clk);
        for (int k = 0; k < ND * SD; k++) begin
          @(negedge clk);
          check("digit_en_onehot", $onehot(digit_en), 1);
          for (int i = 0; i < ND; i++) if (digit_en[i]) shadow[i] = segments;
        end
        for (int i = 0; i < ND; i++)
          check($sformatf("seg_digit%0d_of_%0d", i, disp_q[0]), shadow[i], exp_seg(disp_q[0], i));
        void'(disp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_segments", segments, 0);
    check("reset_digit_en", digit_en, 0);
    check("reset_tick", tick, 0);
    check("reset_wrap", wrap, 0);

    // Count up for 40 cycles straight out of reset while watching the scan.
    dir = 1'b1;
    plan_en(40);
    reset = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("scan_digit_en", digit_en, 32'd1 << (k / 2));
      if (k == 0) check("first_segments", segments, 7'h3F);
    end
    repeat (32) @(negedge clk);
    en = 1'b0;
    check_display();

    // Pause mid-period with the prescaler at 2.
    run_en(2);
    repeat (10) @(negedge clk);
    check_display();
    run_en(2);

    run_en(124);
    check_display();
    run_en(324);
    run_en(3);

    // Clear wins over a terminal-cycle enable.
    clear = 1'b1;
    en = 1'b1;
    @(negedge clk);
    check("clear_tick", tick, 0);
    check("clear_wrap", wrap, 0);
    clear = 1'b0;
    en = 1'b0;
    model_cnt = 0;
    model_p = 0;
    check_display();
    run_en(4);

    run_en(39992);
    check_display();
    run_en(4);
    check_display();

    dir = 1'b0;
    run_en(4);
    check_display();
    run_en(4);
    check_display();

    // Reset in the middle of a scan.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_segments", segments, 0);
    check("midreset_digit_en", digit_en, 0);
    check("midreset_tick", tick, 0);
    check("midreset_wrap", wrap, 0);
    reset = 1'b0;
    model_cnt = 0;
    model_p = 0;
    @(negedge clk);
    check("post_reset_digit_en", digit_en, 4'b0001);
    check("post_reset_segments", segments, 7'h3F);
    check_display();

    check("ticks_outstanding", tick_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_mux_counter.md
Name: seg7_mux_counter

Overview:
- Parametrised successor to the single-digit seconds display: an N-digit BCD up/down counter driven by a configurable prescaler.
- Time-multiplexes the digits onto one shared 7-segment bus with a one-hot digit-enable vector.
- Sits between the 8-bit user I/O wrapper and the external multi-digit display; reuses the team's seg7 decoder.

Parameters:
- NUM_DIGITS, 4, number of BCD decades and digit-enable lines; legal range 1..8.
- PRESCALE, 1000, clk cycles per count step; must be >= 2.
- SCAN_DIV, 4, clk cycles each digit is shown before the scan advances; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- en  input  1  count enable; when low, the prescaler and count hold.
- dir  input  1  count direction: 1 = up, 0 = down.
- clear  input  1  synchronous clear of the prescaler and count.
- segments  output  7  registered, active-high; bit0 = a .. bit6 = g.
- digit_en  output  NUM_DIGITS  registered, one-hot, active-high digit select; bit0 = least-significant digit.
- tick  output  1  registered one-cycle pulse per count step.
- wrap  output  1  registered one-cycle pulse when the whole counter wraps.

Behaviour:
- Reset:
  - Prescaler = 0, all digits = 0, scan index = 0, scan counter = 0.
  - segments = 0, digit_en = 0, tick = 0, wrap = 0.
- Priority: reset > clear > en.
- clear:
  - Zeroes the prescaler and all digits; forces tick = 0 and wrap = 0 for that edge.
  - Does not touch the scan logic.
- Prescaler: width $clog2(PRESCALE); counts 0..PRESCALE-1 while en = 1.
- Terminal cycle (prescaler == PRESCALE-1 with en = 1):
  - At the next edge the prescaler returns to 0, the count steps once, and tick = 1 for exactly that one cycle.
  - Step period is therefore exactly PRESCALE cycles.
- en = 0: prescaler, digits, tick (0) and wrap (0) all hold; the scan keeps running.
- dir is sampled only in the terminal cycle; changing it mid-period has no other effect.
- Count up:
  - digit0 + 1; a digit at 9 goes to 0 and carries into the next digit.
  - All digits at 9 -> all 0, with wrap = 1 coincident with tick.
- Count down:
  - digit0 - 1; a digit at 0 goes to 9 and borrows from the next digit.
  - All digits at 0 -> all 9, with wrap = 1 coincident with tick.
- Digits never hold values above 9.
- Scan:
  - scan counter runs 0..SCAN_DIV-1 every cycle after reset.
  - At its terminal value the index advances idx -> (idx+1) mod NUM_DIGITS.
- Display outputs:
  - Each edge registers digit_en = 1 << idx and segments = decode(digit[idx]), so both are always mutually aligned.
  - The first cycle after reset release shows digit_en = 1, segments = 7'h3F.
  - With NUM_DIGITS = 1, digit_en is constantly 1 after reset.
- Display reflects a count change at most one cycle after the step.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Any digit above the most-significant non-zero digit drives segments = 0 while selected.
  - digit_en is still asserted for that digit.
  - digit0 is never blanked, so value 0 shows a single "0".
- Undefined: every digit is always decoded, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - bcd_t (4-bit) typedef.
  - Segment constants SEG_0..SEG_9 and SEG_BLANK (7'h00).
  - BCD_MAX = 4'd9.
- Sub-module bcd_digit: one decade.
  - Inputs: clk, reset, clear, step, dir, carry_in.
  - Outputs: value, carry_out (set at 9 going up, or at 0 going down, when stepped).
  - Instantiated NUM_DIGITS times in a ripple chain; wrap = carry_out of the top digit.
- The existing seg7 decoder is instantiated once on the muxed digit.

Test Plan:
Run with NUM_DIGITS = 4, PRESCALE = 4, SCAN_DIV = 2 unless noted.
- Reset then en = 1, dir = 1 for 40 cycles -> tick every 4th cycle; count reaches 0010; digit_en cycles 0001, 0010, 0100, 1000 with 2 cycles each.
- Preload to 9999 by counting, then one more step -> all digits 0000; wrap and tick both high for exactly 1 cycle.
- From 0000 with dir = 0, one step -> 9999 with wrap = 1; next step -> 9998 with wrap = 0.
- en = 0 for 10 cycles mid-period (prescaler = 2) -> count and prescaler frozen, scan continues; re-enable -> tick 2 cycles later.
- Assert clear and en together at count 0123 -> next cycle count 0000, prescaler 0, tick 0. Then reset mid-scan -> all outputs 0 for one cycle; first displayed digit_en = 0001, segments = 7'h3F.
- Build with SEG7_LEADING_ZERO_BLANK_EN at count 0042 -> segments 0 while digit_en = 1000 and 0100; digits 1 and 0 show "4" (7'h66) and "2" (7'h5B).
